// File: rtl/branch_hazard_stall_unit.sv
// ID-stage stall/flush controller: stalls assert combinationally on detection and release N cycles later; no backpressure input.
// Define STALL_STATS_EN to add the StallCount/FlushCount statistics counters.
module branch_hazard_stall_unit #(
    parameter int unsigned LOAD_BRANCH_STALLS = 2,
    parameter int unsigned ALU_BRANCH_STALLS  = 1
`ifdef STALL_STATS_EN
    ,
    parameter int unsigned STAT_W             = 32
`endif
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [1:0]        Branch,
    input  logic              BranchTaken,
    input  logic [4:0]        IF_ID_RegisterRs,
    input  logic [4:0]        IF_ID_RegisterRt,
    input  logic              ID_EX_RegWrite,
    input  logic              ID_EX_MemRead,
    input  logic [4:0]        ID_EX_RegisterRd,
    input  logic              EX_MEM_MemRead,
    input  logic [4:0]        EX_MEM_RegisterRd,
    output logic              PCWrite,
    output logic              IF_ID_Write,
    output logic              ID_EX_Bubble,
    output logic              IF_ID_Flush,
`ifdef STALL_STATS_EN
    output logic [STAT_W-1:0] StallCount,
    output logic [STAT_W-1:0] FlushCount,
`endif
    output logic              StallActive
);

    typedef enum logic {IDLE, STALL} state_t;

    localparam logic [1:0] LB_N = 2'(LOAD_BRANCH_STALLS);
    localparam logic [1:0] AB_N = 2'(ALU_BRANCH_STALLS);

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [1:0] need;
    logic       is_br, match_ex, match_mem;
    logic       stall_raw, flush_raw, stall_eff, flush_eff;

    assign is_br     = (Branch != 2'b00);
    assign match_ex  = (ID_EX_RegisterRd != 5'd0) &&
                       (ID_EX_RegisterRd == IF_ID_RegisterRs || ID_EX_RegisterRd == IF_ID_RegisterRt);
    assign match_mem = (EX_MEM_RegisterRd != 5'd0) &&
                       (EX_MEM_RegisterRd == IF_ID_RegisterRs || EX_MEM_RegisterRd == IF_ID_RegisterRt);

    // Priority order matters: a load in EX must win over its own RegWrite.
    always_comb begin
        need = 2'd0;
        if (is_br && ID_EX_MemRead && match_ex)
            need = LB_N;
        else if (is_br && ID_EX_RegWrite && match_ex)
            need = AB_N;
        else if (is_br && EX_MEM_MemRead && match_mem)
            need = 2'd1;
        else if (!is_br && ID_EX_MemRead && match_ex)
            need = 2'd1;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_raw = 1'b0;
        flush_raw = 1'b0;
        case (state_q)
            IDLE: begin
                if (need != 2'd0) begin
                    stall_raw = 1'b1;
                    cnt_d     = need - 2'd1;
                    state_d   = (need > 2'd1) ? STALL : IDLE;
                end else begin
                    flush_raw = is_br && BranchTaken;
                end
            end
            STALL: begin
                stall_raw = 1'b1;
                cnt_d     = cnt_q - 2'd1;
                if (cnt_q == 2'd1)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign stall_eff    = stall_raw && !RESET;
    assign flush_eff    = flush_raw && !RESET;
    assign PCWrite      = !stall_eff;
    assign IF_ID_Write  = !stall_eff;
    assign ID_EX_Bubble = stall_eff;
    assign StallActive  = stall_eff;
    assign IF_ID_Flush  = flush_eff;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef STALL_STATS_EN
    logic [STAT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_eff)
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (flush_eff)
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;
`endif

endmodule

// File: tb/tb_branch_hazard_stall_unit.sv
// Table-driven bench with an expected-output queue; stats counters checked when STALL_STATS_EN is defined.
module tb_branch_hazard_stall_unit;

    typedef struct {
        logic       rst;
        logic [1:0] br;
        logic       tk;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       exrw;
        logic       exmr;
        logic [4:0] exrd;
        logic       mmr;
        logic [4:0] mrd;
        logic [4:0] exp;   // {PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, StallActive}
    } vec_t;

    typedef struct {
        logic [4:0] exp;
        logic       rst;
        int         idx;
    } sb_t;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [1:0] Branch = 2'b00;
    logic       BranchTaken = 1'b0;
    logic [4:0] IF_ID_RegisterRs = 5'd0;
    logic [4:0] IF_ID_RegisterRt = 5'd0;
    logic       ID_EX_RegWrite = 1'b0;
    logic       ID_EX_MemRead = 1'b0;
    logic [4:0] ID_EX_RegisterRd = 5'd0;
    logic       EX_MEM_MemRead = 1'b0;
    logic [4:0] EX_MEM_RegisterRd = 5'd0;
    logic       PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, StallActive;
`ifdef STALL_STATS_EN
    logic [31:0] StallCount, FlushCount;
    int unsigned m_stall = 0;
    int unsigned m_flush = 0;
    bit          m_vld = 0;
`endif

    int checks = 0;
    int errors = 0;
    int vec_no = 0;
    sb_t exp_q[$];
    vec_t tbl[21];

    branch_hazard_stall_unit #(
        .LOAD_BRANCH_STALLS(2),
        .ALU_BRANCH_STALLS (1)
`ifdef STALL_STATS_EN
        ,
        .STAT_W            (32)
`endif
    ) dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .Branch            (Branch),
        .BranchTaken       (BranchTaken),
        .IF_ID_RegisterRs  (IF_ID_RegisterRs),
        .IF_ID_RegisterRt  (IF_ID_RegisterRt),
        .ID_EX_RegWrite    (ID_EX_RegWrite),
        .ID_EX_MemRead     (ID_EX_MemRead),
        .ID_EX_RegisterRd  (ID_EX_RegisterRd),
        .EX_MEM_MemRead    (EX_MEM_MemRead),
        .EX_MEM_RegisterRd (EX_MEM_RegisterRd),
        .PCWrite           (PCWrite),
        .IF_ID_Write       (IF_ID_Write),
        .ID_EX_Bubble      (ID_EX_Bubble),
        .IF_ID_Flush       (IF_ID_Flush),
`ifdef STALL_STATS_EN
        .StallCount        (StallCount),
        .FlushCount        (FlushCount),
`endif
        .StallActive       (StallActive)
    );

    always #5 CLK = ~CLK;

    function automatic vec_t mk(input logic rst, input logic [1:0] br, input logic tk,
                                input logic [4:0] rs, input logic [4:0] rt,
                                input logic exrw, input logic exmr, input logic [4:0] exrd,
                                input logic mmr, input logic [4:0] mrd, input logic [4:0] exp);
        vec_t v;
        v.rst = rst; v.br = br; v.tk = tk; v.rs = rs; v.rt = rt;
        v.exrw = exrw; v.exmr = exmr; v.exrd = exrd; v.mmr = mmr; v.mrd = mrd; v.exp = exp;
        return v;
    endfunction

    task automatic step(input vec_t v);
        sb_t e;
        @(posedge CLK);
        #1;
        RESET             = v.rst;
        Branch            = v.br;
        BranchTaken       = v.tk;
        IF_ID_RegisterRs  = v.rs;
        IF_ID_RegisterRt  = v.rt;
        ID_EX_RegWrite    = v.exrw;
        ID_EX_MemRead     = v.exmr;
        ID_EX_RegisterRd  = v.exrd;
        EX_MEM_MemRead    = v.mmr;
        EX_MEM_RegisterRd = v.mrd;
        e.exp = v.exp;
        e.rst = v.rst;
        e.idx = vec_no;
        exp_q.push_back(e);
        vec_no++;
    endtask

    always @(negedge CLK) begin
        sb_t e;
        logic [4:0] act;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act = {PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, StallActive};
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL outputs vec%0d: got %b want %b", e.idx, act, e.exp);
            end
`ifdef STALL_STATS_EN
            if (m_vld) begin
                checks++;
                if (StallCount !== m_stall || FlushCount !== m_flush) begin
                    errors++;
                    $display("FAIL stats vec%0d: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                             e.idx, StallCount, FlushCount, m_stall, m_flush);
                end
            end
            if (e.rst) begin
                m_stall = 0;
                m_flush = 0;
                m_vld   = 1;
            end else begin
                m_stall = m_stall + {31'd0, e.exp[0]};
                m_flush = m_flush + {31'd0, e.exp[1]};
            end
`endif
        end
    end

    initial begin
        //               rst br tk rs rt rw mr rd mmr mrd  expected
        tbl[0]  = mk(1, 2'd1, 1, 5'd1, 5'd2, 1, 1, 5'd1,  0, 5'd0, 5'b11000); // reset forces defaults
        tbl[1]  = mk(0, 2'd0, 0, 5'd0, 5'd0, 0, 0, 5'd0,  0, 5'd0, 5'b11000);
        tbl[2]  = mk(0, 2'd1, 1, 5'd1, 5'd2, 1, 0, 5'd1,  0, 5'd0, 5'b00101); // ALU -> beq
        tbl[3]  = mk(0, 2'd1, 1, 5'd1, 5'd2, 0, 0, 5'd0,  0, 5'd0, 5'b11010); // re-eval, taken
        tbl[4]  = mk(0, 2'd2, 0, 5'd2, 5'd1, 1, 1, 5'd1,  0, 5'd0, 5'b00101); // lw -> bne
        tbl[5]  = mk(0, 2'd2, 1, 5'd2, 5'd1, 1, 1, 5'd1,  1, 5'd1, 5'b00101); // STALL ignores inputs
        tbl[6]  = mk(0, 2'd2, 0, 5'd2, 5'd1, 0, 0, 5'd0,  0, 5'd0, 5'b11000);
        tbl[7]  = mk(0, 2'd0, 0, 5'd3, 5'd4, 1, 1, 5'd3,  0, 5'd0, 5'b00101); // load-use
        tbl[8]  = mk(0, 2'd0, 0, 5'd3, 5'd4, 0, 0, 5'd0,  1, 5'd3, 5'b11000); // MEM load, no branch
        tbl[9]  = mk(0, 2'd0, 0, 5'd0, 5'd0, 1, 1, 5'd0,  0, 5'd0, 5'b11000); // $0
        tbl[10] = mk(0, 2'd0, 0, 5'd5, 5'd7, 1, 1, 5'd7,  0, 5'd0, 5'b00101); // load-use on rt
        tbl[11] = mk(0, 2'd1, 0, 5'd4, 5'd6, 0, 0, 5'd0,  1, 5'd4, 5'b00101); // load in MEM -> beq
        tbl[12] = mk(0, 2'd1, 1, 5'd4, 5'd6, 0, 0, 5'd0,  0, 5'd0, 5'b11010);
        tbl[13] = mk(0, 2'd0, 1, 5'd5, 5'd6, 1, 0, 5'd5,  0, 5'd0, 5'b11000); // ALU, non-branch
        tbl[14] = mk(0, 2'd1, 1, 5'd0, 5'd0, 1, 1, 5'd0,  1, 5'd0, 5'b11010); // $0 on branch
        tbl[15] = mk(0, 2'd2, 1, 5'd8, 5'd9, 1, 0, 5'd10, 0, 5'd0, 5'b11010); // no match, taken
        tbl[16] = mk(0, 2'd1, 0, 5'd1, 5'd2, 1, 0, 5'd1,  0, 5'd0, 5'b00101); // back-to-back stalls
        tbl[17] = mk(0, 2'd1, 0, 5'd1, 5'd2, 0, 0, 5'd0,  1, 5'd1, 5'b00101);
        tbl[18] = mk(0, 2'd1, 0, 5'd1, 5'd2, 0, 0, 5'd0,  0, 5'd0, 5'b11000);
        tbl[19] = mk(1, 2'd1, 0, 5'd1, 5'd2, 1, 1, 5'd1,  0, 5'd0, 5'b11000); // reset at detection
        tbl[20] = mk(0, 2'd1, 0, 5'd1, 5'd2, 0, 0, 5'd0,  0, 5'd0, 5'b11000); // no residual stall

        for (int i = 0; i < 21; i++)
            step(tbl[i]);

        // reset arriving in the second cycle of a two-cycle load->branch stall
        step(mk(0, 2'd2, 0, 5'd2, 5'd1, 0, 1, 5'd1, 0, 5'd0, 5'b00101));
        step(mk(1, 2'd2, 1, 5'd2, 5'd1, 0, 1, 5'd1, 0, 5'd0, 5'b11000));
        step(mk(0, 2'd0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 5'b11000));

        // ALU stall, load stall, taken flush back to back: 3 stall cycles, 1 flush
        step(mk(1, 2'd0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 5'b11000));
        step(mk(0, 2'd1, 0, 5'd1, 5'd2, 1, 0, 5'd1, 0, 5'd0, 5'b00101));
        step(mk(0, 2'd2, 0, 5'd2, 5'd1, 1, 1, 5'd1, 0, 5'd0, 5'b00101));
        step(mk(0, 2'd2, 0, 5'd2, 5'd1, 0, 0, 5'd0, 0, 5'd0, 5'b00101));
        step(mk(0, 2'd1, 1, 5'd1, 5'd2, 0, 0, 5'd0, 0, 5'd0, 5'b11010));
        step(mk(0, 2'd0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 5'b11000));
        step(mk(1, 2'd0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 5'b11000));
        step(mk(0, 2'd0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 5'b11000));

        for (int i = 0; i < 4 && exp_q.size() > 0; i++)
            @(negedge CLK);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
